// File: rtl/hazard_stall_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller_if
//
// Data-memory request/ready handshake between the pipeline's stall
// controller and the data memory.
//
// Signals
//   dmem_valid  request strobe, driven by the controller (master)
//   dmem_ready  access completes this cycle, driven by memory (slave)
//
// Modports
//   master  controller side: drives dmem_valid, observes dmem_ready
//   slave   memory side:     observes dmem_valid, drives dmem_ready
// ---------------------------------------------------------------------------
interface hazard_stall_controller_if;
  logic dmem_valid;
  logic dmem_ready;

  modport master (
    output dmem_valid,
    input  dmem_ready
  );

  modport slave (
    input  dmem_valid,
    output dmem_ready
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Each cycle
// it decides whether PC and IF/ID advance, whether ID/EX receives a bubble
// and whether IF/ID is squashed. It also sequences the data-memory
// request/ready handshake (with a timeout trap) and freezes the back half
// of the pipeline while memory is outstanding. Saturating performance
// counters track stall, flush and memory-wait cycles.
//
// Parameters
//   MEM_TIMEOUT  WAIT cycles allowed before the memory error trap (1..65535)
//   CNT_WIDTH    width of each performance counter
//
// Ports
//   clk                rising-edge clock
//   reset_n            asynchronous active-low reset
//   ID_rs1/ID_rs2      source registers of the instruction in ID
//   ID_uses_rs1/rs2    ID instruction really reads that source
//   ID_is_ecall        ID instruction is ECALL (implicitly reads x17)
//   ID_EX_rd           destination of the producer in EX
//   ID_EX_mem_read     producer in EX is a load
//   ID_EX_reg_write    producer in EX writes a register
//   EX_MEM_rd          destination of the producer in MEM
//   EX_MEM_mem_read    producer in MEM is a load
//   EX_MEM_mem_access  MEM-stage instruction is a load or store
//   EX_mispredict      branch/jump resolved in EX with a wrong next PC
//   dmem               data-memory handshake (master modport)
//   pc_write           PC enable
//   IF_ID_write        IF/ID enable
//   ID_EX_bubble       insert NOP into ID/EX
//   IF_ID_flush        squash IF/ID
//   pipe_freeze        hold ID/EX, EX/MEM and MEM/WB
//   mem_error          sticky memory-timeout flag
//   stall_cnt          hazard stall cycles (saturating)
//   flush_cnt          unfrozen mispredict cycles (saturating)
//   memwait_cnt        memory-busy cycles, including ERROR (saturating)
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [4:0]                ID_rs1,
  input  logic [4:0]                ID_rs2,
  input  logic                      ID_uses_rs1,
  input  logic                      ID_uses_rs2,
  input  logic                      ID_is_ecall,
  input  logic [4:0]                ID_EX_rd,
  input  logic                      ID_EX_mem_read,
  input  logic                      ID_EX_reg_write,
  input  logic [4:0]                EX_MEM_rd,
  input  logic                      EX_MEM_mem_read,
  input  logic                      EX_MEM_mem_access,
  input  logic                      EX_mispredict,
  hazard_stall_controller_if.master dmem,
  output logic                      pc_write,
  output logic                      IF_ID_write,
  output logic                      ID_EX_bubble,
  output logic                      IF_ID_flush,
  output logic                      pipe_freeze,
  output logic                      mem_error,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic [CNT_WIDTH-1:0]      memwait_cnt
);

  // Memory FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  localparam logic [15:0]          TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [15:0]          WAIT_ONE    = 16'd1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [15:0]          r_wait_cnt;
  logic                 r_mem_error;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic [CNT_WIDTH-1:0] r_memwait_cnt;

  logic [1:0]  w_state_nxt;
  logic [15:0] w_wait_cnt_nxt;
  logic        w_mem_error_set;
  logic        w_mem_busy;
  logic        w_dmem_valid;
  logic        w_load_use;
  logic        w_ecall_haz;
  logic        w_hazard_stall;
  logic        w_flush_cycle;

  // Operand hazards that forwarding cannot cover. x0 is never a real
  // dependency, so a load targeting x0 never stalls.
  always_comb begin
    w_load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                 ((ID_uses_rs1 && (ID_rs1 == ID_EX_rd)) ||
                  (ID_uses_rs2 && (ID_rs2 == ID_EX_rd)));
  end

  // ECALL reads a7 (x17) in ID, so it must wait for any producer of x17 in
  // EX, and additionally for a load of x17 that has only reached MEM.
  always_comb begin
    w_ecall_haz = ID_is_ecall &&
                  ((ID_EX_reg_write && (ID_EX_rd == 5'd17)) ||
                   (EX_MEM_mem_read && (EX_MEM_rd == 5'd17)));
  end

  // Memory handshake outputs. The busy term drives the pipeline freeze; a
  // ready response in WAIT releases the freeze in the same cycle so an
  // N-cycle latency costs exactly N frozen cycles.
  always_comb begin
    w_dmem_valid = 1'b0;
    w_mem_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dmem_valid = EX_MEM_mem_access;
        w_mem_busy   = EX_MEM_mem_access && !dmem.dmem_ready;
      end
      S_WAIT: begin
        w_dmem_valid = 1'b1;
        w_mem_busy   = !dmem.dmem_ready;
      end
      S_ERROR: begin
        w_dmem_valid = 1'b0;
        w_mem_busy   = 1'b0 | 1'b1;
      end
      default: begin
        w_dmem_valid = 1'b0;
        w_mem_busy   = 1'b1;
      end
    endcase
  end

  assign dmem.dmem_valid = w_dmem_valid;

  // Memory FSM next state. The wait counter holds the number of busy cycles
  // already spent on the current access; reaching MEM_TIMEOUT while still
  // not ready traps into ERROR, which only reset can leave.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_mem_error_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EX_MEM_mem_access && !dmem.dmem_ready) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = WAIT_ONE;
        end
      end
      S_WAIT: begin
        if (dmem.dmem_ready) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = 16'd0;
        end else if (r_wait_cnt == TIMEOUT_VAL) begin
          w_state_nxt     = S_ERROR;
          w_mem_error_set = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  // Pipeline control priority: memory freeze, then mispredict redirect,
  // then hazard stall. During a freeze nothing moves, so a pending
  // mispredict or hazard is still presented by EX/ID once it clears. A
  // mispredict wins over a hazard because the ID instruction is squashed.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (w_mem_busy) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (EX_mispredict) begin
      pc_write     = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (w_load_use || w_ecall_haz) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  // Counter event qualifiers follow the same priority as the controls.
  always_comb begin
    w_flush_cycle  = !w_mem_busy && EX_mispredict;
    w_hazard_stall = !w_mem_busy && !EX_mispredict && (w_load_use || w_ecall_haz);
  end

  // Memory FSM state, wait counter and sticky error flag. Asynchronous
  // reset drops any outstanding request immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 16'd0;
      r_mem_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_mem_error_set) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  // Performance counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_memwait_cnt <= '0;
    end else begin
      if (w_hazard_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush_cycle && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
      if (w_mem_busy && (r_memwait_cnt != CNT_MAX)) begin
        r_memwait_cnt <= r_memwait_cnt + CNT_ONE;
      end
    end
  end

  assign mem_error   = r_mem_error;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign memwait_cnt = r_memwait_cnt;

endmodule
